// File: rtl/term_frame_pipe.sv
// term_frame_pipe: passes frame data and strobes on to the next tile after a
// fixed register delay, and captures the frames addressed to this tile.
//
// Ports:
//   UserCLK       in   clock, rising edge
//   resetn        in   synchronous active-low reset
//   FrameData     in   [FrameBitsPerRow]  incoming frame data
//   FrameStrobe   in   [MaxFramesPerCol]  incoming frame strobes
//   FrameData_O   out  [FrameBitsPerRow]  FrameData delayed by PIPE_STAGES
//   FrameStrobe_O out  [MaxFramesPerCol]  FrameStrobe delayed by PIPE_STAGES
//   UserCLKo      out  UserCLK forwarded combinationally
//   ConfigBits    out  [LOCAL_FRAMES*FrameBitsPerRow] captured local frames
//                      (one dummy zero bit when LOCAL_FRAMES = 0)
//   cfg_err       out  sticky flag: several strobes rose in the same cycle
//   cfg_wr_count  out  [8] accepted local frame writes, saturating at 255
module term_frame_pipe #(
  parameter int unsigned MaxFramesPerCol = 20,
  parameter int unsigned FrameBitsPerRow = 32,
  parameter int unsigned PIPE_STAGES     = 2,
  parameter int unsigned LOCAL_FRAMES    = 2
) (
  input  logic                       UserCLK,
  input  logic                       resetn,
  input  logic [FrameBitsPerRow-1:0] FrameData,
  input  logic [MaxFramesPerCol-1:0] FrameStrobe,
  output logic [FrameBitsPerRow-1:0] FrameData_O,
  output logic [MaxFramesPerCol-1:0] FrameStrobe_O,
  output logic                       UserCLKo,
  output logic [((LOCAL_FRAMES > 0) ? LOCAL_FRAMES * FrameBitsPerRow : 1)-1:0] ConfigBits,
  output logic                       cfg_err,
  output logic [7:0]                 cfg_wr_count
);

  // Clock forwarding is a plain wire so reset never touches it.
  assign UserCLKo = UserCLK;

  // Frame path: data and strobe travel together through the same stages.
  if (PIPE_STAGES == 0) begin : gNoPipe
    assign FrameData_O   = FrameData;
    assign FrameStrobe_O = FrameStrobe;
  end else begin : gPipe
    logic [FrameBitsPerRow-1:0] dataQ   [PIPE_STAGES];
    logic [MaxFramesPerCol-1:0] strobeQ [PIPE_STAGES];

    always_ff @(posedge UserCLK) begin
      if (!resetn) begin
        for (int i = 0; i < PIPE_STAGES; i++) begin
          dataQ[i]   <= '0;
          strobeQ[i] <= '0;
        end
      end else begin
        dataQ[0]   <= FrameData;
        strobeQ[0] <= FrameStrobe;
        for (int i = 1; i < PIPE_STAGES; i++) begin
          dataQ[i]   <= dataQ[i-1];
          strobeQ[i] <= strobeQ[i-1];
        end
      end
    end

    assign FrameData_O   = dataQ[PIPE_STAGES-1];
    assign FrameStrobe_O = strobeQ[PIPE_STAGES-1];
  end

  // Rising-edge detection on the raw strobes, across every strobe line.
  logic [MaxFramesPerCol-1:0] strobePrev;
  logic [MaxFramesPerCol-1:0] rise;
  logic                       multiRise;
  logic                       singleRise;

  always_comb begin
    rise       = FrameStrobe & ~strobePrev;
    // x & (x-1) clears the lowest set bit; anything left means two or more rose.
    multiRise  = (rise & (rise - MaxFramesPerCol'(1))) != '0;
    singleRise = (rise != '0) && !multiRise;
  end

  // Previous-strobe copy resets to 0, so a strobe held through reset release
  // is seen as a fresh edge.
  always_ff @(posedge UserCLK) begin
    if (!resetn) begin
      strobePrev <= '0;
      cfg_err    <= 1'b0;
    end else begin
      strobePrev <= FrameStrobe;
      if (multiRise) begin
        cfg_err <= 1'b1;
      end
    end
  end

  // Local capture: only a lone rising strobe that addresses this tile writes.
  if (LOCAL_FRAMES == 0) begin : gNoLocal
    assign ConfigBits   = '0;
    assign cfg_wr_count = '0;
  end else begin : gLocal
    logic [LOCAL_FRAMES-1:0] wrEn;

    assign wrEn = rise[LOCAL_FRAMES-1:0] & {LOCAL_FRAMES{singleRise}};

    always_ff @(posedge UserCLK) begin
      if (!resetn) begin
        ConfigBits   <= '0;
        cfg_wr_count <= '0;
      end else begin
        for (int k = 0; k < LOCAL_FRAMES; k++) begin
          if (wrEn[k]) begin
            ConfigBits[k*FrameBitsPerRow +: FrameBitsPerRow] <= FrameData;
          end
        end
        if ((wrEn != '0) && (cfg_wr_count != 8'hFF)) begin
          cfg_wr_count <= cfg_wr_count + 8'd1;
        end
      end
    end
  end

endmodule
